uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between PORTS AXI-stream byte sources.
- Arbitration is round-robin and frame-based: a grant is held until tlast or until MAX_BURST bytes have been accepted, whichever comes first.
- Output is a registered single-beat AXI stream that connects directly to the uart_tx input stream.
- Sits between per-client message generators (debug, status, console) and the single UART pin.

Parameters:
PORTS, 4, number of requesters; range 2..16
DATA_WIDTH, 8, byte width; must equal the uart_tx DATA_WIDTH
MAX_BURST, 16, maximum beats per grant; range 1..256
TAG_BASE, 8'hF0, tag byte base value; used only with UART_TX_ARB_TAG_EN

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
s_axis_tdata  input  PORTS*DATA_WIDTH  packed input bytes; port i occupies [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  input  PORTS  per-port valid
s_axis_tlast  input  PORTS  per-port end of frame
s_axis_tready  output  PORTS  per-port ready
m_axis_tdata  output  DATA_WIDTH  byte to uart_tx
m_axis_tvalid  output  1  valid to uart_tx
m_axis_tready  input  1  ready from uart_tx
grant  output  PORTS  one-hot current grant; all zero when none
busy  output  1  state != IDLE or m_axis_tvalid

Behaviour:
- Reset (async): state=IDLE, grant=0, priority pointer=0, beat count=0, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, busy=0.
- States: IDLE, (TAG when enabled), XFER.
- IDLE arbitration:
  - If any s_axis_tvalid is high, select the first asserted index scanning from the pointer upward, wrapping modulo PORTS.
  - Register the result as grant; next state is XFER.
  - Arbitration costs one cycle. No grant is made when all tvalid are low.
- XFER:
  - s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready) for the granted port g; all other ready bits are 0.
  - s_axis_tready is combinational from state, grant and m_axis_tready only; never from s_axis_tvalid.
  - On an accepted beat (valid && ready): load the output register with the port's byte, set m_axis_tvalid=1, increment the beat count.
  - Release the grant when the accepted beat has tlast=1 or the count reaches MAX_BURST-1. On release: pointer <= g+1 (wrap to 0 past PORTS-1), count <= 0, grant <= 0, state <= IDLE.
- Output register:
  - m_axis_tvalid clears when m_axis_tready is high and no new beat is loaded in the same cycle.
  - Simultaneous drain and load keeps tvalid=1 with the new data, so full throughput holds while uart_tx is ready.
  - m_axis_tdata and m_axis_tvalid are stable while tvalid && !tready.
- Latency: input accept to m_axis_tvalid is 1 cycle. Back-to-back frames from different ports have a 1-cycle input-side bubble (IDLE).
- Grant hold: a granted port that deasserts tvalid mid-frame keeps the grant indefinitely; there is no timeout.
- Single active requester: it is re-granted after every release, each time after a 1-cycle IDLE.
- Fairness: with all ports requesting, grants rotate 0,1,2,...,PORTS-1,0.
- MAX_BURST=1: every beat releases the grant. tlast on the MAX_BURST-th beat is a single release, not two.
- Reset mid-frame: any pending output byte is discarded and all state returns to reset values. The uart_tx reset is the system's responsibility.
- busy drops only after the final byte has been handed to uart_tx (tvalid && tready), not after the line goes idle.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN
- Defined:
  - After IDLE grants port g, the TAG state loads the output register with TAG_BASE + g, once the register is free.
  - All s_axis_tready are 0 during TAG. The tag does not count toward MAX_BURST.
  - Then go to XFER. Net cost is one output byte per grant.
- Undefined: the TAG state and TAG_BASE logic are absent; IDLE goes directly to XFER.

Test Plan:
- Single port 1 sends the 3-byte frame 0x41,0x42,0x43 (tlast on 0x43), m_axis_tready held at 1 -> m_axis emits 41,42,43 on consecutive cycles one cycle after each accept; grant=4'b0010 for exactly 3 cycles; busy falls after 43 is taken.
- Ports 0..3 each present a 2-byte frame simultaneously after reset -> output frames appear in order p0,p1,p2,p3 with no interleaving inside a frame; pointer ends at 0.
- Port 2 streams 40 bytes with no tlast, MAX_BURST=16, port 3 also requesting -> p2 gets 16 bytes, then p3's frame, then p2 resumes; never more than 16 consecutive p2 bytes.
- m_axis_tready low for 50 cycles mid-frame -> m_axis_tdata/tvalid stable throughout, s_axis_tready low, no byte lost or duplicated after tready returns.
- rst asserted for 1 cycle during byte 2 of a 4-byte frame -> grant=0, m_axis_tvalid=0, busy=0 immediately; the next request arbitrates from pointer 0.
- With UART_TX_ARB_TAG_EN and TAG_BASE=8'hF0, port 1 sends 0x55 with tlast -> m_axis emits F1 then 55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-based arbiter sharing one uart_tx between PORTS byte streams.
// Optional macro UART_TX_ARB_TAG_EN prefixes every grant with a tag byte TAG_BASE + port.
module uart_tx_arbiter #(
    parameter int                    PORTS      = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_BURST  = 16,
    parameter logic [DATA_WIDTH-1:0] TAG_BASE   = DATA_WIDTH'(8'hF0)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [PORTS-1:0]            grant,
    output logic                        busy
);

    localparam int IDX_W = $clog2(PORTS);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PORTS - 1);

`ifdef UART_TX_ARB_TAG_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_TAG = 2'd2} state_t;
`else
    typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;
`endif

    state_t                 state_q;
    logic [PORTS-1:0]       grant_q;
    logic [IDX_W-1:0]       gidx_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  tdata_q;
    logic                   tvalid_q;

    logic                   out_free;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_last;
    logic                   accept;
    logic                   rel;
    logic                   arb_found_d;
    logic [IDX_W-1:0]       arb_idx_d;
    int                     cand;

    // Valid/ready: a beat moves on a source port when tvalid && tready are both high at
    // the rising clock edge; the output beat moves when m_axis_tvalid && m_axis_tready.
    // Ready never depends on the source's own tvalid.
    assign out_free = !tvalid_q || m_axis_tready;
    assign sel_data = s_axis_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last = s_axis_tlast[gidx_q];
    assign accept   = (state_q == S_XFER) && out_free && s_axis_tvalid[gidx_q];
    assign rel      = accept && (sel_last || (cnt_q == CNT_LAST));

    assign s_axis_tready = ((state_q == S_XFER) && out_free) ? grant_q : '0;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign grant         = grant_q;
    assign busy          = (state_q != S_IDLE) || tvalid_q;

    // First requester at or after the priority pointer, wrapping modulo PORTS.
    always_comb begin
        arb_found_d = 1'b0;
        arb_idx_d   = '0;
        cand        = 0;
        for (int k = 0; k < PORTS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= PORTS) cand = cand - PORTS;
            if (!arb_found_d && s_axis_tvalid[cand]) begin
                arb_found_d = 1'b1;
                arb_idx_d   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_found_d) begin
                        grant_q <= PORTS'(1) << arb_idx_d;
                        gidx_q  <= arb_idx_d;
`ifdef UART_TX_ARB_TAG_EN
                        state_q <= S_TAG;
`else
                        state_q <= S_XFER;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                S_TAG: begin
                    if (out_free) state_q <= S_XFER;
                end
`endif
                S_XFER: begin
                    if (rel) begin
                        ptr_q   <= (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
                        cnt_q   <= '0;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A load in the same cycle as a drain keeps tvalid high for full throughput.
            if (accept) begin
                tdata_q  <= sel_data;
                tvalid_q <= 1'b1;
            end
`ifdef UART_TX_ARB_TAG_EN
            else if ((state_q == S_TAG) && out_free) begin
                tdata_q  <= TAG_BASE + DATA_WIDTH'(gidx_q);
                tvalid_q <= 1'b1;
            end
`endif
            else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-port source queues, output scoreboard.
module tb_uart_tx_arbiter;

    localparam int NP = 4;
`ifdef UART_TX_ARB_TAG_EN
    localparam int TAG_N = 1;
`else
    localparam int TAG_N = 0;
`endif

    logic            clk;
    logic            rst;
    logic [NP*8-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tlast;
    logic [NP-1:0]   s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [NP-1:0]   grant;
    logic            busy;

    uart_tx_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .busy          (busy)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [8:0] src_q[NP][$];
    logic [7:0] exp_q[$];
    int         acc_cyc_q[$];
    int         out_cyc_q[$];
    int         gcnt[NP];
    logic [NP-1:0] drv_fire;
    logic [8:0]    drv_head;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time=%0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    // Source driver and output scoreboard: handshakes are decided at the negedge
    // (signals settled) and queues advance just after the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            drv_fire = '0;
            if (!rst) begin
                drv_fire = s_axis_tvalid & s_axis_tready;
                for (int i = 0; i < NP; i++) begin
                    if (drv_fire[i]) acc_cyc_q.push_back(cyc);
                    if (grant[i]) gcnt[i]++;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    out_cyc_q.push_back(cyc);
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard: unexpected byte %h, expected none", m_axis_tdata);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (m_axis_tdata !== e) begin
                            n_fail++;
                            $display("FAIL scoreboard: got %h expected %h", m_axis_tdata, e);
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (drv_fire[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    drv_head                = src_q[i][0];
                    s_axis_tvalid[i]        = 1'b1;
                    s_axis_tdata[i*8 +: 8]  = drv_head[7:0];
                    s_axis_tlast[i]         = drv_head[8];
                end else begin
                    s_axis_tvalid[i]        = 1'b0;
                    s_axis_tlast[i]         = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic push_frame(input int p, input logic [7:0] base, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            src_q[p].push_back({last && (i == n - 1), base + 8'(i)});
            exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic exp_grant(input int p);
        if (TAG_N != 0) exp_q.push_back(8'hF0 + 8'(p));
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            gcnt[i] = 0;
        end
        exp_q.delete();
        acc_cyc_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (exp_q.size() == 0) ok = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        clear_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (grant !== 4'b0000 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 ||
            s_axis_tready !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: grant=%b tvalid=%b tdata=%h tready=%b busy=%b, expected all zero",
                     grant, m_axis_tvalid, m_axis_tdata, s_axis_tready, busy);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_tests++;
        if (grant !== 4'b0000 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_request: grant=%b busy=%b tvalid=%b, expected 0 0 0", grant, busy, m_axis_tvalid);
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        clear_all();
        exp_grant(1);
        push_frame(1, 8'h41, 3, 1'b1);
        wait_drain(100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain: %0d bytes left, expected 0", exp_q.size());
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_hold: busy=%b before last handoff, expected 1", busy);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_busy_drop: busy=%b grant=%b, expected 0 0000", busy, grant);
        end
        n_tests++;
        if (gcnt[1] != 3 + TAG_N || gcnt[0] != 0 || gcnt[2] != 0 || gcnt[3] != 0) begin
            n_fail++;
            $display("FAIL single_grant_cycles: g0..g3=%0d %0d %0d %0d, expected 0 %0d 0 0",
                     gcnt[0], gcnt[1], gcnt[2], gcnt[3], 3 + TAG_N);
        end
        n_tests++;
        if (acc_cyc_q.size() != 3 || out_cyc_q.size() != 3 + TAG_N) begin
            n_fail++;
            $display("FAIL single_counts: accepts=%0d outputs=%0d, expected 3 %0d",
                     acc_cyc_q.size(), out_cyc_q.size(), 3 + TAG_N);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (out_cyc_q[i + TAG_N] != acc_cyc_q[i] + 1 || acc_cyc_q[i] != acc_cyc_q[0] + i) begin
                    n_fail++;
                    $display("FAIL single_latency: beat %0d accept cyc %0d out cyc %0d, expected out=accept+1 consecutive",
                             i, acc_cyc_q[i], out_cyc_q[i + TAG_N]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        pulse_reset();
        for (int p = 0; p < NP; p++) begin
            exp_grant(p);
            push_frame(p, 8'(p * 16), 2, 1'b1);
        end
        wait_drain(200, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fairness_drain: %0d bytes left, expected 0", exp_q.size());
        end
        // Pointer must be back at 0: port 0 wins over port 3.
        clear_all();
        exp_grant(0);
        push_frame(0, 8'h0A, 1, 1'b1);
        exp_grant(3);
        push_frame(3, 8'h3A, 1, 1'b1);
        wait_drain(100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fairness_pointer: %0d bytes left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_burst_limit();
        bit ok;
        clear_all();
        for (int i = 0; i < 40; i++) src_q[2].push_back({1'b0, 8'(i)});
        src_q[3].push_back({1'b0, 8'hC0});
        src_q[3].push_back({1'b1, 8'hC1});
        exp_grant(2);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_grant(3);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        exp_grant(2);
        for (int i = 16; i < 32; i++) exp_q.push_back(8'(i));
        exp_grant(2);
        for (int i = 32; i < 40; i++) exp_q.push_back(8'(i));
        wait_drain(400, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL burst_drain: %0d bytes left, expected 0", exp_q.size());
        end
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_grant_hold: grant=%b busy=%b, expected 0100 1", grant, busy);
        end
        push_frame(2, 8'h28, 1, 1'b1);
        wait_drain(100, ok);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (!ok || grant !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_release: ok=%b grant=%b busy=%b, expected 1 0000 0", ok, grant, busy);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit stable;
        int n;
        logic [7:0] hold;
        clear_all();
        exp_grant(0);
        push_frame(0, 8'hA0, 4, 1'b1);
        n = 0;
        while (exp_q.size() > 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_axis_tready = 1'b0;
        @(negedge clk);
        #1;
        hold   = m_axis_tdata;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold || s_axis_tready !== 4'b0000) stable = 1'b0;
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (!stable || hold !== 8'hA2) begin
            n_fail++;
            $display("FAIL stall_stable: stable=%b held=%h, expected 1 a2", stable, hold);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_drain(100, ok);
        repeat (4) @(negedge clk);
        #1;
        n_tests++;
        if (!ok || out_cyc_q.size() != 4 + TAG_N) begin
            n_fail++;
            $display("FAIL stall_count: ok=%b outputs=%0d, expected 1 %0d", ok, out_cyc_q.size(), 4 + TAG_N);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n;
        clear_all();
        exp_grant(1);
        push_frame(1, 8'hB0, 4, 1'b1);
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (grant !== 4'b0000 || m_axis_tvalid !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_clear: grant=%b tvalid=%b busy=%b tready=%b, expected all zero",
                     grant, m_axis_tvalid, busy, s_axis_tready);
        end
        clear_all();
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_grant(0);
        push_frame(0, 8'h0D, 1, 1'b1);
        exp_grant(1);
        push_frame(1, 8'h1D, 1, 1'b1);
        wait_drain(100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midreset_pointer: %0d bytes left, expected 0", exp_q.size());
        end
    endtask

`ifdef UART_TX_ARB_TAG_EN
    task automatic test_tag();
        bit ok;
        clear_all();
        exp_q.push_back(8'hF1);
        src_q[1].push_back({1'b1, 8'h55});
        exp_q.push_back(8'h55);
        wait_drain(100, ok);
        n_tests++;
        if (!ok || out_cyc_q.size() != 2) begin
            n_fail++;
            $display("FAIL tag_frame: ok=%b outputs=%0d, expected 1 2", ok, out_cyc_q.size());
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        test_reset();
        test_single_frame();
        test_fairness();
        test_burst_limit();
        test_stall();
        test_reset_mid_frame();
`ifdef UART_TX_ARB_TAG_EN
        test_tag();
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
